macc_dot_sequencer: RTL

Sequencer for one DSP48 pre-add multiply-accumulate slice (25-bit pre-adder, 18-bit multiplier, 48-bit accumulator, LATENCY-cycle pipeline). It accepts a job (term count plus bias) and streams terms through a valid/ready input. It drives the slice's CE, LOAD, LOAD_DATA, PREADD1, PREADD2 and MULTIPLIER pins, drains the pipeline and returns the 48-bit dot product on a valid/ready result port. It sits beside the MAC instance; the slice's RST pin is tied to the same RST.

---
 rtl/macc_dot_sequencer_if.sv | 57 +++++
 rtl/macc_dot_sequencer.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/macc_dot_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module   : macc_dot_sequencer_if
// Purpose  : Bundles the job, term, result and MAC-slice pins of the
//            dot-product sequencer. The slave side is the sequencer; the
//            master side is everything around it (job source, result sink
//            and the MAC slice that returns PRODUCT).
// Revision : 1.0 - initial release
// ============================================================================
interface macc_dot_sequencer_if #(
  parameter int WIDTH_PREADD     = 25,
  parameter int WIDTH_MULTIPLIER = 18,
  parameter int WIDTH_PRODUCT    = 48,
  parameter int WIDTH_LEN        = 16
);
  // Job request / status
  logic                        start;
  logic [WIDTH_LEN-1:0]        len;
  logic [WIDTH_PRODUCT-1:0]    bias;
  logic                        busy;

  // Term stream
  logic                        in_valid;
  logic                        in_ready;
  logic [WIDTH_PREADD-1:0]     in_a;
  logic [WIDTH_PREADD-1:0]     in_b;
  logic [WIDTH_MULTIPLIER-1:0] in_c;

  // MAC slice pins
  logic                        mac_ce;
  logic                        mac_load;
  logic [WIDTH_PRODUCT-1:0]    mac_load_data;
  logic [WIDTH_PREADD-1:0]     mac_preadd1;
  logic [WIDTH_PREADD-1:0]     mac_preadd2;
  logic [WIDTH_MULTIPLIER-1:0] mac_multiplier;
  logic [WIDTH_PRODUCT-1:0]    mac_product;

  // Result
  logic                        res_valid;
  logic                        res_ready;
  logic [WIDTH_PRODUCT-1:0]    res_data;

  // Environment side: issues jobs and terms, sinks results, hosts the MAC
  modport master (
    output start, len, bias, in_valid, in_a, in_b, in_c, res_ready, mac_product,
    input  busy, in_ready, res_valid, res_data,
    input  mac_ce, mac_load, mac_load_data, mac_preadd1, mac_preadd2, mac_multiplier
  );

  // Sequencer side
  modport slave (
    input  start, len, bias, in_valid, in_a, in_b, in_c, res_ready, mac_product,
    output busy, in_ready, res_valid, res_data,
    output mac_ce, mac_load, mac_load_data, mac_preadd1, mac_preadd2, mac_multiplier
  );
endinterface
`default_nettype wire

// File: rtl/macc_dot_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : macc_dot_sequencer
// Purpose  : Drives one pre-add multiply-accumulate slice through a dot
//            product: loads the bias with the first term, accumulates the
//            remaining terms, flushes the slice pipeline with zero terms and
//            holds the result on a valid/ready port.
// Revision : 1.0 - initial release
// ============================================================================
module macc_dot_sequencer #(
  parameter int LATENCY          = 4,
  parameter int WIDTH_PREADD     = 25,
  parameter int WIDTH_MULTIPLIER = 18,
  parameter int WIDTH_PRODUCT    = 48,
  parameter int WIDTH_LEN        = 16
) (
  input  wire logic            clk,
  input  wire logic            rst,
  macc_dot_sequencer_if.slave  bus
);

  // Drain counter only has to reach LATENCY-1; keep at least one bit.
  localparam int c_drain_w = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [c_drain_w-1:0] c_drain_last = c_drain_w'(LATENCY - 1);
  localparam logic [c_drain_w-1:0] c_drain_one  = c_drain_w'(1);
  localparam logic [WIDTH_LEN-1:0] c_len_one    = WIDTH_LEN'(1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t                      r_state;
  logic [WIDTH_LEN-1:0]        r_len;
  logic [WIDTH_LEN-1:0]        r_count;
  logic [WIDTH_PRODUCT-1:0]    r_bias;
  logic [c_drain_w-1:0]        r_drain;
  logic [WIDTH_PRODUCT-1:0]    r_res_data;
  logic                        r_busy;
  logic                        r_in_ready;
  logic                        r_res_valid;

  logic                        w_accept;
  logic                        w_last_term;
  logic                        w_mac_ce;
  logic                        w_mac_load;
  logic [WIDTH_PRODUCT-1:0]    w_mac_load_data;
  logic [WIDTH_PREADD-1:0]     w_mac_preadd1;
  logic [WIDTH_PREADD-1:0]     w_mac_preadd2;
  logic [WIDTH_MULTIPLIER-1:0] w_mac_multiplier;

  // in_ready is a pure function of state, so a term is accepted exactly
  // when the source offers one while the sequencer sits in RUN.
  assign w_accept    = r_in_ready & bus.in_valid;
  assign w_last_term = (r_count == (r_len - c_len_one));

  // Job control FSM; busy, in_ready and res_valid are registered alongside
  // the state so they never glitch on input activity.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_len       <= '0;
      r_count     <= '0;
      r_bias      <= '0;
      r_drain     <= '0;
      r_res_data  <= '0;
      r_busy      <= 1'b0;
      r_in_ready  <= 1'b0;
      r_res_valid <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (bus.start) begin
            r_busy <= 1'b1;
            if (bus.len != '0) begin
              r_len      <= bus.len;
              r_bias     <= bus.bias;
              r_count    <= '0;
              r_in_ready <= 1'b1;
              r_state    <= ST_RUN;
            end else begin
              // Empty job: the bias is the answer and the slice stays idle.
              r_res_data  <= bus.bias;
              r_res_valid <= 1'b1;
              r_state     <= ST_DONE;
            end
          end
        end

        ST_RUN: begin
          if (w_accept) begin
            r_count <= r_count + c_len_one;
            if (w_last_term) begin
              r_drain    <= '0;
              r_in_ready <= 1'b0;
              r_state    <= ST_DRAIN;
            end
          end
        end

        ST_DRAIN: begin
          r_drain <= r_drain + c_drain_one;
          // PRODUCT carries the final sum during the last drain cycle.
          if (r_drain == c_drain_last) begin
            r_res_data  <= bus.mac_product;
            r_res_valid <= 1'b1;
            r_state     <= ST_DONE;
          end
        end

        ST_DONE: begin
          if (bus.res_ready) begin
            r_res_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_state     <= ST_IDLE;
          end
        end

        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  // MAC pin drive: operands pass straight through in RUN, zero terms flush
  // the pipeline in DRAIN, everything is quiet otherwise.
  always_comb begin
    w_mac_ce         = 1'b0;
    w_mac_load       = 1'b0;
    w_mac_load_data  = '0;
    w_mac_preadd1    = '0;
    w_mac_preadd2    = '0;
    w_mac_multiplier = '0;
    case (r_state)
      ST_RUN: begin
        w_mac_ce         = w_accept;
        w_mac_load       = (r_count == '0);
        w_mac_load_data  = r_bias;
        w_mac_preadd1    = bus.in_a;
        w_mac_preadd2    = bus.in_b;
        w_mac_multiplier = bus.in_c;
      end
      ST_DRAIN: begin
        w_mac_ce = 1'b1;
      end
      default: begin
      end
    endcase
  end

  assign bus.busy           = r_busy;
  assign bus.in_ready       = r_in_ready;
  assign bus.res_valid      = r_res_valid;
  assign bus.res_data       = r_res_data;
  assign bus.mac_ce         = w_mac_ce;
  assign bus.mac_load       = w_mac_load;
  assign bus.mac_load_data  = w_mac_load_data;
  assign bus.mac_preadd1    = w_mac_preadd1;
  assign bus.mac_preadd2    = w_mac_preadd2;
  assign bus.mac_multiplier = w_mac_multiplier;

endmodule
`default_nettype wire
